// File: rtl/wb_commit_queue.sv
`default_nettype none
// ============================================================================
// Module      : wb_commit_queue
// Description : Write-back stage with an in-order commit queue of DEPTH
//               completed instructions. The head retires when the register
//               file write port grants it. Exceptions, interrupts and ERET
//               are resolved precisely at the head and flush the queue. A
//               forwarding lookup scans every queued entry for decode bypass.
// Ports       : clk/resetn             - clock, synchronous active-low reset
//               ms_* / ws_allowin      - entry offered by the memory stage
//               has_int                - pending interrupt, taken at the head
//               rf_*                   - GPR write port (rf_ready = grant)
//               cp0_*                  - CP0 read, exception, mtc0 and eret
//               ws_flush               - pipeline flush
//               fwd_*                  - forwarding query and result
//               ws_count               - occupancy
//               debug_wb_*             - retirement trace
// Revision    : 1.0 - initial release
// ============================================================================
module wb_commit_queue #(
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     ms_to_ws_valid,
    output logic                     ws_allowin,
    input  logic                     ms_gr_we,
    input  logic [4:0]               ms_dest,
    input  logic [DW-1:0]            ms_result,
    input  logic [31:0]              ms_pc,
    input  logic                     ms_res_from_cp0,
    input  logic                     ms_mtc0_we,
    input  logic [4:0]               ms_cp0_addr,
    input  logic [DW-1:0]            ms_rt_value,
    input  logic                     ms_eret,
    input  logic                     ms_ex,
    input  logic [4:0]               ms_excode,
    input  logic [31:0]              ms_badvaddr,
    input  logic                     ms_inst_addr_ex,
    input  logic                     ms_bd,
    input  logic                     has_int,
    input  logic                     rf_ready,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [DW-1:0]            rf_wdata,
    output logic [4:0]               cp0_raddr,
    input  logic [DW-1:0]            cp0_rdata,
    output logic                     cp0_ex,
    output logic [4:0]               cp0_excode,
    output logic [31:0]              cp0_badvaddr,
    output logic                     cp0_bd,
    output logic [31:0]              cp0_epc,
    output logic                     cp0_mtc0_we,
    output logic [4:0]               cp0_waddr,
    output logic [DW-1:0]            cp0_wdata,
    output logic                     cp0_eret,
    output logic                     ws_flush,
    input  logic [4:0]               fwd_addr,
    output logic                     fwd_hit,
    output logic                     fwd_wait,
    output logic [DW-1:0]            fwd_data,
    output logic [$clog2(DEPTH):0]   ws_count,
    output logic [31:0]              debug_wb_pc,
    output logic [3:0]               debug_wb_rf_wen,
    output logic [4:0]               debug_wb_rf_wnum,
    output logic [31:0]              debug_wb_rf_wdata
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_full = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_one  = (AW+1)'(1);

    typedef struct packed {
        logic          gr_we;
        logic [4:0]    dest;
        logic [DW-1:0] result;
        logic [31:0]   pc;
        logic          res_from_cp0;
        logic          mtc0_we;
        logic [4:0]    cp0_addr;
        logic [DW-1:0] rt_value;
        logic          eret;
        logic          ex;
        logic [4:0]    excode;
        logic [31:0]   badvaddr;
        logic          inst_addr_ex;
        logic          bd;
    } entry_t;

    entry_t        r_q [DEPTH];
    logic [AW:0]   r_rd_ptr;
    logic [AW:0]   r_wr_ptr;

    logic [AW:0]   w_count;
    logic          w_head_valid;
    entry_t        w_head;
    entry_t        w_new;
    logic          w_head_exc;
    logic          w_eret_go;
    logic          w_flush;
    logic          w_retire;
    logic          w_enq;
    logic [DW-1:0] w_rf_wdata;
    logic [AW-1:0] w_scan_idx  [DEPTH];
    logic          w_scan_live [DEPTH];

    // Pointer difference wraps naturally because pointers carry one extra bit.
    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign ws_count = w_count;

    // Holding resetn low masks the head so nothing commits while resetting.
    assign w_head_valid = resetn && (w_count != '0);
    assign w_head       = r_q[r_rd_ptr[AW-1:0]];

    assign w_head_exc = w_head_valid && (w_head.ex || has_int);
    assign w_eret_go  = w_head_valid && w_head.eret && !w_head_exc;
    assign w_flush    = w_head_exc || w_eret_go;
    assign w_retire   = w_head_valid &&
                        (w_head_exc || w_head.eret || !w_head.gr_we || rf_ready);

    // A full queue refuses entries even if the head retires this cycle.
    assign ws_allowin = (w_count != c_full) && !w_flush;
    assign w_enq      = ms_to_ws_valid && ws_allowin;

    assign w_new = '{gr_we: ms_gr_we, dest: ms_dest, result: ms_result,
                     pc: ms_pc, res_from_cp0: ms_res_from_cp0,
                     mtc0_we: ms_mtc0_we, cp0_addr: ms_cp0_addr,
                     rt_value: ms_rt_value, eret: ms_eret, ex: ms_ex,
                     excode: ms_excode, badvaddr: ms_badvaddr,
                     inst_addr_ex: ms_inst_addr_ex, bd: ms_bd};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_enq)    r_wr_ptr <= r_wr_ptr + c_one;
            if (w_retire) r_rd_ptr <= r_rd_ptr + c_one;
        end
    end

    // Entry storage needs no reset: occupancy is defined by the pointers.
    always_ff @(posedge clk) begin
        if (resetn && w_enq) r_q[r_wr_ptr[AW-1:0]] <= w_new;
    end

    // GPR write port
    assign rf_we      = w_head_valid && !w_flush && w_head.gr_we && rf_ready;
    assign rf_waddr   = w_head_valid ? w_head.dest : 5'd0;
    assign w_rf_wdata = !w_head_valid       ? '0 :
                        w_head.res_from_cp0 ? cp0_rdata : w_head.result;
    assign rf_wdata   = w_rf_wdata;

    // CP0 interface
    assign cp0_raddr    = w_head_valid ? w_head.cp0_addr : 5'd0;
    assign cp0_ex       = w_head_exc;
    assign cp0_excode   = !w_head_exc ? 5'd0 : (has_int ? 5'd0 : w_head.excode);
    assign cp0_badvaddr = !w_head_exc ? 32'd0 :
                          (w_head.inst_addr_ex ? w_head.pc : w_head.badvaddr);
    assign cp0_epc      = w_head_exc ? w_head.pc : 32'd0;
    assign cp0_bd       = w_head_exc && w_head.bd;
    assign cp0_mtc0_we  = w_retire && !w_flush && w_head.mtc0_we;
    assign cp0_waddr    = w_head_valid ? w_head.cp0_addr : 5'd0;
    assign cp0_wdata    = w_head_valid ? w_head.rt_value : '0;
    assign cp0_eret     = w_eret_go;
    assign ws_flush     = w_flush;

    // Trace
    assign debug_wb_pc       = w_head_valid ? w_head.pc : 32'd0;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = 32'(w_rf_wdata);

    // Scan slots in age order starting at the head; slot g is live when it
    // lies within the current occupancy.
    for (genvar g = 0; g < DEPTH; g++) begin : g_scan
        assign w_scan_idx[g]  = r_rd_ptr[AW-1:0] + AW'(g);
        assign w_scan_live[g] = resetn && ((AW+1)'(g) < w_count);
    end

    // Later (younger) matches overwrite earlier ones, so the youngest wins.
    // The head still counts even in the cycle it retires.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_wait = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_scan_live[i] && r_q[w_scan_idx[i]].gr_we &&
                r_q[w_scan_idx[i]].dest == fwd_addr && fwd_addr != 5'd0) begin
                fwd_hit  = 1'b1;
                fwd_wait = r_q[w_scan_idx[i]].res_from_cp0;
                fwd_data = r_q[w_scan_idx[i]].result;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_commit_queue
// Description : Directed self-checking bench for wb_commit_queue (DW=32,
//               DEPTH=2). Expected GPR writes are queued when an entry that
//               should commit is offered and are matched against every rf_we.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_commit_queue;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ms_to_ws_valid, ws_allowin;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_result, ms_pc;
    logic        ms_res_from_cp0, ms_mtc0_we;
    logic [4:0]  ms_cp0_addr;
    logic [31:0] ms_rt_value;
    logic        ms_eret, ms_ex;
    logic [4:0]  ms_excode;
    logic [31:0] ms_badvaddr;
    logic        ms_inst_addr_ex, ms_bd;
    logic        has_int, rf_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic        cp0_ex;
    logic [4:0]  cp0_excode;
    logic [31:0] cp0_badvaddr;
    logic        cp0_bd;
    logic [31:0] cp0_epc;
    logic        cp0_mtc0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic        cp0_eret, ws_flush;
    logic [4:0]  fwd_addr;
    logic        fwd_hit, fwd_wait;
    logic [31:0] fwd_data;
    logic [1:0]  ws_count;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int n_cmp = 0;
    int n_bad = 0;
    logic [36:0] sb[$];

    wb_commit_queue #(.DW(32), .DEPTH(2)) dut (
        .clk(clk), .resetn(resetn),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result), .ms_pc(ms_pc),
        .ms_res_from_cp0(ms_res_from_cp0), .ms_mtc0_we(ms_mtc0_we),
        .ms_cp0_addr(ms_cp0_addr), .ms_rt_value(ms_rt_value), .ms_eret(ms_eret),
        .ms_ex(ms_ex), .ms_excode(ms_excode), .ms_badvaddr(ms_badvaddr),
        .ms_inst_addr_ex(ms_inst_addr_ex), .ms_bd(ms_bd),
        .has_int(has_int), .rf_ready(rf_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
        .cp0_ex(cp0_ex), .cp0_excode(cp0_excode), .cp0_badvaddr(cp0_badvaddr),
        .cp0_bd(cp0_bd), .cp0_epc(cp0_epc),
        .cp0_mtc0_we(cp0_mtc0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
        .cp0_eret(cp0_eret), .ws_flush(ws_flush),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_wait(fwd_wait), .fwd_data(fwd_data),
        .ws_count(ws_count),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic idle;
        ms_to_ws_valid = 0; ms_gr_we = 0; ms_dest = 0; ms_result = 0; ms_pc = 0;
        ms_res_from_cp0 = 0; ms_mtc0_we = 0; ms_cp0_addr = 0; ms_rt_value = 0;
        ms_eret = 0; ms_ex = 0; ms_excode = 0; ms_badvaddr = 0;
        ms_inst_addr_ex = 0; ms_bd = 0;
    endtask

    task automatic offer(input logic [4:0] dest, input logic [31:0] data, input logic [31:0] pc);
        idle();
        ms_to_ws_valid = 1; ms_gr_we = 1; ms_dest = dest; ms_result = data; ms_pc = pc;
    endtask

    task automatic push(input logic [4:0] dest, input logic [31:0] data);
        sb.push_back({dest, data});
    endtask

    // Scoreboard: every GPR write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {27'd0, rf_waddr, rf_wdata}, 64'd0);
            end else begin
                logic [36:0] e;
                e = sb.pop_front();
                chk("rf_write", {27'd0, rf_waddr, rf_wdata}, {27'd0, e});
                chk("debug_wen", 64'(debug_wb_rf_wen), 64'hf);
            end
        end
    end

    initial begin
        resetn = 0; rf_ready = 1; has_int = 0; fwd_addr = 0; cp0_rdata = 32'hABCD;
        idle();
        tick; tick;
        resetn = 1;
        settle;
        chk("rst_count", 64'(ws_count), 0);
        chk("rst_allowin", 64'(ws_allowin), 1);
        chk("rst_rf_we", 64'(rf_we), 0);
        chk("rst_flush", 64'(ws_flush), 0);
        chk("rst_fwd_hit", 64'(fwd_hit), 0);
        chk("rst_cp0_ex", 64'(cp0_ex), 0);
        chk("rst_debug_pc", 64'(debug_wb_pc), 0);

        // Back-to-back writes, one-cycle latency
        tick; offer(1, 5, 32'h10); push(1, 5); settle; chk("b2b_cnt0", 64'(ws_count), 0);
        tick; offer(2, 6, 32'h14); push(2, 6); settle; chk("b2b_cnt1", 64'(ws_count), 1);
        chk("b2b_rf_we", 64'(rf_we), 1);
        tick; offer(3, 7, 32'h18); push(3, 7); settle; chk("b2b_cnt2", 64'(ws_count), 1);
        tick; idle(); settle; chk("b2b_cnt3", 64'(ws_count), 1);
        tick; settle; chk("b2b_empty", 64'(ws_count), 0); chk("b2b_no_we", 64'(rf_we), 0);

        // Stall to full, then drain
        tick; rf_ready = 0; offer(1, 32'h10, 32'h20); push(1, 32'h10); settle;
        tick; offer(2, 32'h20, 32'h24); push(2, 32'h20); settle;
        tick; offer(3, 32'h30, 32'h28); push(3, 32'h30); settle;
        chk("full_cnt", 64'(ws_count), 2); chk("full_allowin", 64'(ws_allowin), 0);
        chk("stall_no_we", 64'(rf_we), 0);
        tick; settle; chk("full_hold", 64'(ws_count), 2);
        tick; rf_ready = 1; settle;
        chk("full_retire_allowin", 64'(ws_allowin), 0); chk("full_retire_we", 64'(rf_we), 1);
        tick; settle; chk("drain_cnt", 64'(ws_count), 1); chk("drain_allowin", 64'(ws_allowin), 1);
        tick; idle(); settle; chk("drain_cnt2", 64'(ws_count), 1);
        tick; settle; chk("drain_empty", 64'(ws_count), 0);

        // Exception at head with a younger entry offered behind it
        tick; rf_ready = 0; offer(6, 32'h66, 32'h1f0); push(6, 32'h66); settle;
        tick; offer(5, 32'h55, 32'h200); ms_ex = 1; ms_excode = 4; ms_badvaddr = 32'h1003; ms_bd = 1;
        settle;
        tick; offer(7, 32'h77, 32'h204); settle; chk("ex_cnt", 64'(ws_count), 2);
        tick; rf_ready = 1; settle;
        tick; settle;
        chk("ex_cp0_ex", 64'(cp0_ex), 1); chk("ex_excode", 64'(cp0_excode), 4);
        chk("ex_badvaddr", 64'(cp0_badvaddr), 32'h1003); chk("ex_epc", 64'(cp0_epc), 32'h200);
        chk("ex_bd", 64'(cp0_bd), 1); chk("ex_rf_we", 64'(rf_we), 0);
        chk("ex_flush", 64'(ws_flush), 1); chk("ex_allowin", 64'(ws_allowin), 0);
        tick; idle(); settle; chk("ex_after_cnt", 64'(ws_count), 0); chk("ex_after_ex", 64'(cp0_ex), 0);

        tick; offer(8, 0, 32'h300); ms_ex = 1; ms_excode = 4; ms_inst_addr_ex = 1; ms_badvaddr = 32'h1234;
        settle;
        tick; idle(); settle; chk("iaex_badvaddr", 64'(cp0_badvaddr), 32'h300);
        tick; settle; chk("iaex_cnt", 64'(ws_count), 0);

        // Interrupts
        tick; has_int = 1; settle; chk("int_empty_ex", 64'(cp0_ex), 0); chk("int_empty_flush", 64'(ws_flush), 0);
        tick; has_int = 0; offer(8, 0, 32'h400); ms_res_from_cp0 = 1; ms_cp0_addr = 12; settle;
        tick; idle(); has_int = 1; settle;
        chk("int_ex", 64'(cp0_ex), 1); chk("int_excode", 64'(cp0_excode), 0);
        chk("int_rf_we", 64'(rf_we), 0); chk("int_flush", 64'(ws_flush), 1);
        chk("int_epc", 64'(cp0_epc), 32'h400);
        tick; has_int = 0; settle; chk("int_cnt", 64'(ws_count), 0);

        // mfc0 commit and mtc0 commit (mtc0 retires without rf_ready)
        tick; offer(9, 0, 32'h410); ms_res_from_cp0 = 1; ms_cp0_addr = 12; push(9, 32'hABCD); settle;
        chk("mfc0_raddr", 64'(cp0_raddr), 0);
        tick; offer(0, 0, 32'h414); ms_gr_we = 0; ms_mtc0_we = 1; ms_cp0_addr = 14; ms_rt_value = 32'h1234;
        settle; chk("mfc0_raddr_head", 64'(cp0_raddr), 12);
        tick; idle(); rf_ready = 0; settle;
        chk("mtc0_we", 64'(cp0_mtc0_we), 1); chk("mtc0_waddr", 64'(cp0_waddr), 14);
        chk("mtc0_wdata", 64'(cp0_wdata), 32'h1234);
        tick; settle; chk("mtc0_cnt", 64'(ws_count), 0); chk("mtc0_we_off", 64'(cp0_mtc0_we), 0);

        // ERET
        tick; rf_ready = 1; offer(0, 0, 32'h500); ms_gr_we = 0; ms_eret = 1; settle;
        tick; idle(); settle;
        chk("eret", 64'(cp0_eret), 1); chk("eret_flush", 64'(ws_flush), 1);
        chk("eret_ex", 64'(cp0_ex), 0); chk("eret_rf_we", 64'(rf_we), 0);
        tick; settle; chk("eret_cnt", 64'(ws_count), 0);

        // Interrupt arriving while the head is stalled on rf_ready
        tick; rf_ready = 0; offer(12, 32'hCC, 32'h600); settle;
        tick; idle(); settle; chk("stall_int_we", 64'(rf_we), 0); chk("stall_int_cnt", 64'(ws_count), 1);
        tick; has_int = 1; settle; chk("stall_int_ex", 64'(cp0_ex), 1); chk("stall_int_epc", 64'(cp0_epc), 32'h600);
        tick; has_int = 0; settle; chk("stall_int_cnt2", 64'(ws_count), 0);

        // Forwarding
        tick; offer(4, 32'h11, 32'h700); push(4, 32'h11); settle;
        tick; offer(4, 32'h22, 32'h704); push(4, 32'h22); settle;
        tick; idle(); fwd_addr = 4; settle;
        chk("fwd_cnt", 64'(ws_count), 2); chk("fwd_hit", 64'(fwd_hit), 1);
        chk("fwd_data", 64'(fwd_data), 32'h22); chk("fwd_wait0", 64'(fwd_wait), 0);
        tick; fwd_addr = 0; settle; chk("fwd_r0_hit", 64'(fwd_hit), 0); chk("fwd_r0_data", 64'(fwd_data), 0);
        tick; fwd_addr = 4; rf_ready = 1; settle; chk("fwd_retiring_data", 64'(fwd_data), 32'h22);
        tick; rf_ready = 0; offer(4, 0, 32'h708); ms_res_from_cp0 = 1; ms_cp0_addr = 12; push(4, 32'hABCD);
        settle;
        tick; idle(); settle;
        chk("fwd_mfc0_cnt", 64'(ws_count), 2); chk("fwd_mfc0_hit", 64'(fwd_hit), 1);
        chk("fwd_mfc0_wait", 64'(fwd_wait), 1);
        tick; fwd_addr = 5; settle; chk("fwd_miss_hit", 64'(fwd_hit), 0); chk("fwd_miss_wait", 64'(fwd_wait), 0);
        tick; fwd_addr = 4; rf_ready = 1; settle;
        tick; settle; chk("fwd_last_cnt", 64'(ws_count), 1); chk("fwd_last_hit", 64'(fwd_hit), 1);
        chk("fwd_last_wait", 64'(fwd_wait), 1);
        tick; settle; chk("fwd_end_cnt", 64'(ws_count), 0); chk("fwd_end_hit", 64'(fwd_hit), 0);

        // Reset with entries queued: nothing may be written
        tick; rf_ready = 0; offer(10, 32'hA0, 32'h800); settle;
        tick; offer(11, 32'hB0, 32'h804); settle;
        tick; idle(); settle; chk("rst2_cnt_before", 64'(ws_count), 2);
        tick; resetn = 0; rf_ready = 1; settle;
        chk("rst2_rf_we", 64'(rf_we), 0); chk("rst2_mtc0", 64'(cp0_mtc0_we), 0);
        tick; resetn = 1; settle;
        chk("rst2_cnt", 64'(ws_count), 0); chk("rst2_allowin", 64'(ws_allowin), 1);
        chk("rst2_no_we", 64'(rf_we), 0);
        tick; tick;

        chk("sb_drained", 64'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
